// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcodes, functs,
// ALU codes, memory size codes and the per-stage control bundle.
package mips_ctrl_pkg;

  localparam int CTRL_ALU_W = 5;
  localparam int CTRL_REG_W = 5;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  // REGIMM branches are selected by the rt field.
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [CTRL_ALU_W-1:0] ALU_NONE = 5'b00000;
  localparam logic [CTRL_ALU_W-1:0] ALU_ADD  = 5'b00001;
  localparam logic [CTRL_ALU_W-1:0] ALU_SUB  = 5'b00010;
  localparam logic [CTRL_ALU_W-1:0] ALU_MUL  = 5'b00011;
  localparam logic [CTRL_ALU_W-1:0] ALU_SLL  = 5'b00100;
  localparam logic [CTRL_ALU_W-1:0] ALU_SRL  = 5'b00101;
  localparam logic [CTRL_ALU_W-1:0] ALU_AND  = 5'b00110;
  localparam logic [CTRL_ALU_W-1:0] ALU_OR   = 5'b00111;
  localparam logic [CTRL_ALU_W-1:0] ALU_XOR  = 5'b01000;
  localparam logic [CTRL_ALU_W-1:0] ALU_EQ   = 5'b01100;
  localparam logic [CTRL_ALU_W-1:0] ALU_NOR  = 5'b01101;
  localparam logic [CTRL_ALU_W-1:0] ALU_SLT  = 5'b01110;
  localparam logic [CTRL_ALU_W-1:0] ALU_NE   = 5'b01111;
  localparam logic [CTRL_ALU_W-1:0] ALU_GTZ  = 5'b10000;
  localparam logic [CTRL_ALU_W-1:0] ALU_LEZ  = 5'b10001;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WORD = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_BYTE = 2'b11;

  typedef struct packed {
    logic                  alu_src;
    logic                  reg_dst;
    logic                  branch;
    logic                  shift_control;
    logic [CTRL_ALU_W-1:0] alu_control;
    logic [1:0]            mem_read;
    logic [1:0]            mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  jal;
    logic [CTRL_REG_W-1:0] write_reg;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  function automatic ctrl_t r_type_ctrl(input logic [CTRL_ALU_W-1:0] alu,
                                        input logic                  shift,
                                        input logic [CTRL_REG_W-1:0] rd);
    ctrl_t c;
    c               = BUBBLE;
    c.reg_dst       = 1'b1;
    c.reg_write     = 1'b1;
    c.shift_control = shift;
    c.alu_control   = alu;
    c.write_reg     = rd;
    return c;
  endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Bus between the IF/ID register / datapath muxes and the pipelined control unit.
interface pipelined_control_unit_if #(
    parameter int INSTR_W   = 32,
    parameter int ALUCTRL_W = 5,
    parameter int REG_W     = 5,
    parameter int CNT_W     = 16
);
    // No valid/ready pair: Instruction is decoded every cycle, and Stall is the
    // only backpressure -- while Stall=1 the fetch side must hold PC and IF/ID.
    logic [INSTR_W-1:0]   Instruction;
    logic                 BranchTaken;
    logic                 Stall;
    logic                 FlushIFID;
    logic                 ID_Jump;
    logic                 ID_Jr;
    logic                 EX_ALUSrc;
    logic                 EX_RegDst;
    logic                 EX_Branch;
    logic                 EX_ShiftControl;
    logic [ALUCTRL_W-1:0] EX_ALUControl;
    logic [1:0]           MEM_MemRead;
    logic [1:0]           MEM_MemWrite;
    logic                 WB_RegWrite;
    logic                 WB_MemToReg;
    logic                 WB_Jal;
    logic [REG_W-1:0]     EX_WriteReg;
    logic [REG_W-1:0]     MEM_WriteReg;
    logic [REG_W-1:0]     WB_WriteReg;
    logic [CNT_W-1:0]     StallCount;

    modport master (
        output Instruction, BranchTaken,
        input  Stall, FlushIFID, ID_Jump, ID_Jr,
        input  EX_ALUSrc, EX_RegDst, EX_Branch, EX_ShiftControl, EX_ALUControl,
        input  MEM_MemRead, MEM_MemWrite, WB_RegWrite, WB_MemToReg, WB_Jal,
        input  EX_WriteReg, MEM_WriteReg, WB_WriteReg, StallCount
    );

    modport slave (
        input  Instruction, BranchTaken,
        output Stall, FlushIFID, ID_Jump, ID_Jr,
        output EX_ALUSrc, EX_RegDst, EX_Branch, EX_ShiftControl, EX_ALUControl,
        output MEM_MemRead, MEM_MemWrite, WB_RegWrite, WB_MemToReg, WB_Jal,
        output EX_WriteReg, MEM_WriteReg, WB_WriteReg, StallCount
    );
endinterface

// File: rtl/pipelined_control_unit_hazard_detect.sv
// Combinational stall request: load-use always; any RAW with EX or MEM when
// there is no forwarding unit.
module hazard_detect
    import mips_ctrl_pkg::*;
#(
    parameter int FORWARD_EN = 1,
    parameter int REG_W      = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [1:0]       ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_write_reg,
    output logic             hazard
);

    function automatic logic src_match(input logic [REG_W-1:0] wr,
                                       input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rt,
                                       input logic             rs_used,
                                       input logic             rt_used);
        return (wr != '0) && ((rs_used && (wr == rs)) || (rt_used && (wr == rt)));
    endfunction

    logic load_use;
    logic raw_ex;
    logic raw_mem;

    always_comb begin
        load_use = (ex_mem_read != MEM_NONE) &&
                   src_match(ex_write_reg, id_rs, id_rt, id_rs_used, id_rt_used);
        raw_ex   = ex_reg_write &&
                   src_match(ex_write_reg, id_rs, id_rt, id_rs_used, id_rt_used);
        raw_mem  = mem_reg_write &&
                   src_match(mem_write_reg, id_rs, id_rt, id_rs_used, id_rt_used);
        hazard   = load_use || ((FORWARD_EN == 0) && (raw_ex || raw_mem));
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Main decoder for the 5-stage MIPS pipeline: decodes IF/ID, carries control
// through ID/EX, EX/MEM and MEM/WB, and handles stalls and flushes.
module pipelined_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int ALUCTRL_W  = 5,
    parameter int REG_W      = 5,
    parameter int FORWARD_EN = 1,
    parameter int CNT_W      = 16
) (
    input logic                     Clk,
    input logic                     Reset,
    pipelined_control_unit_if.slave bus
);

    logic [5:0]            op;
    logic [5:0]            funct;
    logic [CTRL_REG_W-1:0] rs, rt, rd;
    logic                  unused_shamt;

    assign op           = bus.Instruction[INSTR_W-1 -: 6];
    assign rs           = bus.Instruction[25:21];
    assign rt           = bus.Instruction[20:16];
    assign rd           = bus.Instruction[15:11];
    assign funct        = bus.Instruction[5:0];
    assign unused_shamt = ^bus.Instruction[10:6];

    ctrl_t dec;
    logic  id_jump, id_jr, rs_used, rt_used;

    always_comb begin
        dec     = BUBBLE;
        id_jump = 1'b0;
        id_jr   = 1'b0;
        rs_used = 1'b0;
        rt_used = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
                unique case (funct)
                    F_SLL: begin dec = r_type_ctrl(ALU_SLL, 1'b1, rd); rs_used = 1'b0; end
                    F_SRL: begin dec = r_type_ctrl(ALU_SRL, 1'b1, rd); rs_used = 1'b0; end
                    F_JR:  id_jr = 1'b1;
                    F_ADD: dec = r_type_ctrl(ALU_ADD, 1'b0, rd);
                    F_SUB: dec = r_type_ctrl(ALU_SUB, 1'b0, rd);
                    F_MUL: dec = r_type_ctrl(ALU_MUL, 1'b0, rd);
                    F_AND: dec = r_type_ctrl(ALU_AND, 1'b0, rd);
                    F_OR:  dec = r_type_ctrl(ALU_OR,  1'b0, rd);
                    F_XOR: dec = r_type_ctrl(ALU_XOR, 1'b0, rd);
                    F_NOR: dec = r_type_ctrl(ALU_NOR, 1'b0, rd);
                    F_SLT: dec = r_type_ctrl(ALU_SLT, 1'b0, rd);
                    default: begin rs_used = 1'b0; rt_used = 1'b0; end
                endcase
            end
            OP_LW, OP_LH, OP_LB: begin
                dec.alu_src     = 1'b1;
                dec.reg_write   = 1'b1;
                dec.mem_to_reg  = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.write_reg   = rt;
                dec.mem_read    = (op == OP_LW) ? MEM_WORD : (op == OP_LH) ? MEM_HALF : MEM_BYTE;
                rs_used         = 1'b1;
            end
            OP_SW, OP_SH, OP_SB: begin
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_ADD;
                dec.mem_write   = (op == OP_SW) ? MEM_WORD : (op == OP_SH) ? MEM_HALF : MEM_BYTE;
                rs_used         = 1'b1;
                rt_used         = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
                dec.alu_src     = 1'b1;
                dec.reg_write   = 1'b1;
                dec.write_reg   = rt;
                dec.alu_control = (op == OP_ADDI) ? ALU_ADD :
                                  (op == OP_ANDI) ? ALU_AND :
                                  (op == OP_ORI)  ? ALU_OR  :
                                  (op == OP_XORI) ? ALU_XOR : ALU_SLT;
                rs_used         = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.branch      = 1'b1;
                dec.alu_control = (op == OP_BEQ) ? ALU_EQ : ALU_NE;
                rs_used         = 1'b1;
                rt_used         = 1'b1;
            end
            OP_REGIMM: begin
                if (rt == RT_BGEZ || rt == RT_BLTZ) begin
                    dec.branch      = 1'b1;
                    dec.alu_control = (rt == RT_BGEZ) ? ALU_NE : ALU_EQ;
                    rs_used         = 1'b1;
                end
            end
            OP_BGTZ, OP_BLEZ: begin
                dec.branch      = 1'b1;
                dec.alu_control = (op == OP_BGTZ) ? ALU_GTZ : ALU_LEZ;
                rs_used         = 1'b1;
            end
            OP_J: id_jump = 1'b1;
            OP_JAL: begin
                id_jump       = 1'b1;
                dec.reg_write = 1'b1;
                dec.jal       = 1'b1;
                dec.write_reg = 5'd31;
            end
            default: ;
        endcase
    end

    ctrl_t            idex_q, idex_d, exmem_q, exmem_d, memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             hazard, stall, flush;

    hazard_detect #(.FORWARD_EN(FORWARD_EN), .REG_W(CTRL_REG_W)) u_hazard (
        .id_rs        (rs),
        .id_rt        (rt),
        .id_rs_used   (rs_used),
        .id_rt_used   (rt_used),
        .ex_mem_read  (idex_q.mem_read),
        .ex_reg_write (idex_q.reg_write),
        .ex_write_reg (idex_q.write_reg),
        .mem_reg_write(exmem_q.reg_write),
        .mem_write_reg(exmem_q.write_reg),
        .hazard       (hazard)
    );

    // A taken branch squashes the stalled instruction anyway, so it overrides Stall.
    always_comb begin
        stall         = hazard && !bus.BranchTaken && !Reset;
        flush         = !Reset && (bus.BranchTaken || ((id_jump || id_jr) && !stall));
        idex_d        = (bus.BranchTaken || stall) ? BUBBLE : dec;
        exmem_d       = idex_q;
        memwb_d       = exmem_q;
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idex_q        <= BUBBLE;
            exmem_q       <= BUBBLE;
            memwb_q       <= BUBBLE;
            stall_count_q <= '0;
        end else begin
            idex_q        <= idex_d;
            exmem_q       <= exmem_d;
            memwb_q       <= memwb_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Only the WB-relevant fields of MEM/WB leave the block.
    logic unused_wb;
    assign unused_wb = ^memwb_q;

    assign bus.Stall           = stall;
    assign bus.FlushIFID       = flush;
    assign bus.ID_Jump         = id_jump;
    assign bus.ID_Jr           = id_jr;
    assign bus.EX_ALUSrc       = idex_q.alu_src;
    assign bus.EX_RegDst       = idex_q.reg_dst;
    assign bus.EX_Branch       = idex_q.branch;
    assign bus.EX_ShiftControl = idex_q.shift_control;
    assign bus.EX_ALUControl   = ALUCTRL_W'(idex_q.alu_control);
    assign bus.MEM_MemRead     = exmem_q.mem_read;
    assign bus.MEM_MemWrite    = exmem_q.mem_write;
    assign bus.WB_RegWrite     = memwb_q.reg_write;
    assign bus.WB_MemToReg     = memwb_q.mem_to_reg;
    assign bus.WB_Jal          = memwb_q.jal;
    assign bus.EX_WriteReg     = REG_W'(idex_q.write_reg);
    assign bus.MEM_WriteReg    = REG_W'(exmem_q.write_reg);
    assign bus.WB_WriteReg     = REG_W'(memwb_q.write_reg);
    assign bus.StallCount      = stall_count_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: one forwarding instance and one non-forwarding instance
// with a narrow stall counter, fed the same instruction stream.
module tb_pipelined_control_unit;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] LW_2_1   = 32'h8C22_0000; // lw   $2,0($1)
  localparam logic [31:0] LW_2_2   = 32'h8C42_0000; // lw   $2,0($2)
  localparam logic [31:0] ADD_324  = 32'h0044_1820; // add  $3,$2,$4
  localparam logic [31:0] BEQ_12   = 32'h1022_0004; // beq  $1,$2,4
  localparam logic [31:0] ADDI_501 = 32'h2005_0001; // addi $5,$0,1
  localparam logic [31:0] SUB_655  = 32'h00A5_3022; // sub  $6,$5,$5
  localparam logic [31:0] JAL_40   = 32'h0C00_0010; // jal  0x40
  localparam logic [31:0] SH_4_1   = 32'hA424_0002; // sh   $4,2($1)
  localparam logic [31:0] UNK      = 32'hFC00_0000; // opcode 111111

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        br;
  int          passed;
  int          total;

  pipelined_control_unit_if #(.CNT_W(16)) if_f ();
  pipelined_control_unit_if #(.CNT_W(4))  if_n ();

  assign if_f.Instruction = instr;
  assign if_f.BranchTaken = br;
  assign if_n.Instruction = instr;
  assign if_n.BranchTaken = br;

  pipelined_control_unit #(.FORWARD_EN(1), .CNT_W(16)) dut_f (
    .Clk  (clk),
    .Reset(rst),
    .bus  (if_f.slave)
  );

  pipelined_control_unit #(.FORWARD_EN(0), .CNT_W(4)) dut_n (
    .Clk  (clk),
    .Reset(rst),
    .bus  (if_n.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    instr  = NOP;
    br     = 1'b0;
    step();
    step();
    mid();
    chk("rst_stall",     32'(if_f.Stall), 0);
    chk("rst_flush",     32'(if_f.FlushIFID), 0);
    chk("rst_count",     32'(if_f.StallCount), 0);
    chk("rst_ex_alu",    32'(if_f.EX_ALUControl), 0);
    chk("rst_wb_rw",     32'(if_f.WB_RegWrite), 0);
    rst = 1'b0;
    step();

    // load-use: lw $2 then add $3,$2,$4
    instr = LW_2_1;
    mid();
    chk("lu_pre_stall",  32'(if_f.Stall), 0);
    step();
    instr = ADD_324;
    mid();
    chk("lu_stall",      32'(if_f.Stall), 1);
    chk("lu_ex_lw_alu",  32'(if_f.EX_ALUControl), 1);
    chk("lu_ex_lw_src",  32'(if_f.EX_ALUSrc), 1);
    step();
    mid();
    chk("lu_released",   32'(if_f.Stall), 0);
    chk("lu_bubble_alu", 32'(if_f.EX_ALUControl), 0);
    chk("lu_mem_read",   32'(if_f.MEM_MemRead), 1);
    chk("lu_count",      32'(if_f.StallCount), 1);
    step();
    instr = NOP;
    mid();
    chk("add_ex_alu",    32'(if_f.EX_ALUControl), 1);
    chk("add_ex_dst",    32'(if_f.EX_WriteReg), 3);
    chk("add_regdst",    32'(if_f.EX_RegDst), 1);
    chk("lw_wb_m2r",     32'(if_f.WB_MemToReg), 1);
    chk("lw_wb_reg",     32'(if_f.WB_WriteReg), 2);
    step();

    // taken branch overriding a pending load-use stall
    instr = BEQ_12;
    mid();
    step();
    instr = LW_2_1;
    mid();
    chk("beq_ex_branch", 32'(if_f.EX_Branch), 1);
    chk("beq_ex_alu",    32'(if_f.EX_ALUControl), 12);
    step();
    instr = ADD_324;
    br    = 1'b1;
    mid();
    chk("bt_flush",      32'(if_f.FlushIFID), 1);
    chk("bt_stall",      32'(if_f.Stall), 0);
    step();
    br    = 1'b0;
    instr = NOP;
    mid();
    chk("bt_bubble_alu", 32'(if_f.EX_ALUControl), 0);
    chk("bt_bubble_reg", 32'(if_f.EX_WriteReg), 0);
    chk("bt_count",      32'(if_f.StallCount), 1);
    step();

    // RAW without forwarding: addi $5 then sub $6,$5,$5
    rst = 1'b1;
    step();
    rst   = 1'b0;
    instr = ADDI_501;
    mid();
    step();
    instr = SUB_655;
    mid();
    chk("nf_raw_stall1", 32'(if_n.Stall), 1);
    chk("fw_no_stall",   32'(if_f.Stall), 0);
    step();
    mid();
    chk("nf_raw_stall2", 32'(if_n.Stall), 1);
    step();
    mid();
    chk("nf_raw_release", 32'(if_n.Stall), 0);
    step();
    instr = NOP;
    mid();
    chk("nf_count",      32'(if_n.StallCount), 2);
    chk("fw_count",      32'(if_f.StallCount), 0);
    step();

    // jal 0x40
    instr = JAL_40;
    mid();
    chk("jal_id_jump",   32'(if_f.ID_Jump), 1);
    chk("jal_flush",     32'(if_f.FlushIFID), 1);
    step();
    instr = NOP;
    mid();
    step();
    mid();
    step();
    mid();
    chk("jal_wb_jal",    32'(if_f.WB_Jal), 1);
    chk("jal_wb_rw",     32'(if_f.WB_RegWrite), 1);
    chk("jal_wb_reg",    32'(if_f.WB_WriteReg), 31);
    step();

    // store halfword decode
    instr = SH_4_1;
    mid();
    step();
    instr = NOP;
    mid();
    chk("sh_ex_alusrc",  32'(if_f.EX_ALUSrc), 1);
    chk("sh_ex_alu",     32'(if_f.EX_ALUControl), 1);
    step();
    mid();
    chk("sh_mem_write",  32'(if_f.MEM_MemWrite), 2);
    step();

    // reset between edges with a lw in MEM
    instr = LW_2_1;
    mid();
    step();
    instr = ADD_324;
    mid();
    step();
    #1;
    chk("rm_pre_memread", 32'(if_f.MEM_MemRead), 1);
    chk("rm_pre_count",   32'(if_f.StallCount), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rm_memread",    32'(if_f.MEM_MemRead), 0);
    chk("rm_count",      32'(if_f.StallCount), 0);
    chk("rm_stall",      32'(if_f.Stall), 0);
    step();
    chk("rm_hold_count", 32'(if_f.StallCount), 0);
    chk("rm_hold_alu",   32'(if_f.EX_ALUControl), 0);
    rst = 1'b0;

    // unknown opcode
    instr = UNK;
    step();
    step();
    step();
    mid();
    chk("unk_wb_rw",     32'(if_f.WB_RegWrite), 0);
    chk("unk_mem_mw",    32'(if_f.MEM_MemWrite), 0);
    chk("unk_ex_alu",    32'(if_f.EX_ALUControl), 0);
    chk("unk_ex_reg",    32'(if_f.EX_WriteReg), 0);
    chk("unk_flush",     32'(if_f.FlushIFID), 0);
    step();

    // counter saturation with repeated self-dependent load
    rst = 1'b1;
    step();
    rst   = 1'b0;
    instr = LW_2_2;
    repeat (6) step();
    mid();
    chk("nf_partial",    32'(if_n.StallCount), 4);
    chk("fw_partial",    32'(if_f.StallCount), 3);
    step();
    repeat (23) step();
    mid();
    chk("nf_sat",        32'(if_n.StallCount), 15);
    repeat (6) step();
    mid();
    chk("nf_sat_hold",   32'(if_n.StallCount), 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
